// File: rtl/rails_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rails_pkg : shared word type, limits and send-FSM encoding for rails blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package rails_pkg;

  localparam int DATA_W = 4;
  localparam int MAX_N  = 15;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rails_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rails_feeder_if : host word stream, rails word/verdict pins and verdict port
// Rev 1.0
// ----------------------------------------------------------------------------
interface rails_feeder_if;
  import rails_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  word_t rails_data;
  logic  rails_valid;
  logic  rails_result;
  logic  out_valid;
  logic  out_ready;
  logic  out_result;
  logic  out_timeout;

  // master is the environment (host plus rails); slave is the feeder
  modport master (
    output in_valid, in_data, out_ready, rails_valid, rails_result,
    input  in_ready, rails_data, out_valid, out_result, out_timeout
  );

  modport slave (
    input  in_valid, in_data, out_ready, rails_valid, rails_result,
    output in_ready, rails_data, out_valid, out_result, out_timeout
  );

endinterface
`default_nettype wire

// File: rtl/rails_feed_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rails_feed_fifo : show-ahead synchronous word FIFO with full/empty/count
// Rev 1.0
// ----------------------------------------------------------------------------
module rails_feed_fifo
  import rails_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  word_t                    push_data,
  input  logic                     pop,
  output word_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // a pop frees the slot in the same cycle, so push-while-full is legal with it
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != C_FULL) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == C_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/rails_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rails_feeder : buffers host frames, serializes them to rails, returns verdicts
// Rev 1.0
// ----------------------------------------------------------------------------
module rails_feeder
  import rails_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset,
  rails_feeder_if.slave  bus,
  output logic           err_zero,
  output logic           busy
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam int            FW     = $clog2(DEPTH);
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] C_TMAX = TW'(TIMEOUT);

  word_t         fifo_head;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;

  word_t         wr_rem_q, wr_rem_d;
  logic          err_zero_q, err_zero_d;
  logic          frame_done, frame_sent;
  logic [FW-1:0] frames_ready_q, frames_ready_d;

  state_t        state_q, state_d;
  word_t         snd_rem_q, snd_rem_d;
  logic          snd_first_q, snd_first_d;
  logic [TW-1:0] timer_q, timer_d;
  word_t         rails_data_q, rails_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_result_q, out_result_d;
  logic          out_timeout_q, out_timeout_d;

  rails_feed_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // write tracker: wr_rem==0 means the next accepted word is a header
  always_comb begin
    wr_rem_d   = wr_rem_q;
    err_zero_d = err_zero_q;
    fifo_push  = 1'b0;
    frame_done = 1'b0;
    if (bus.in_valid && !fifo_full) begin
      if (wr_rem_q == '0) begin
        if (bus.in_data == '0) begin
          err_zero_d = 1'b1;
        end else begin
          fifo_push = 1'b1;
          wr_rem_d  = bus.in_data;
        end
      end else begin
        fifo_push  = 1'b1;
        wr_rem_d   = wr_rem_q - 1'b1;
        frame_done = (wr_rem_q == word_t'(1));
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    snd_rem_d     = snd_rem_q;
    snd_first_d   = snd_first_q;
    timer_d       = timer_q;
    rails_data_d  = '0;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_timeout_d = out_timeout_q;
    fifo_pop      = 1'b0;
    frame_sent    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((frames_ready_q != '0) && !out_valid_q) begin
          state_d     = SEND;
          snd_first_d = 1'b1;
        end
      end
      SEND: begin
        // the frame is fully buffered, so the head is valid every cycle here
        fifo_pop     = !fifo_empty;
        rails_data_d = fifo_head;
        snd_first_d  = 1'b0;
        if (snd_first_q) begin
          snd_rem_d = fifo_head;
        end else begin
          snd_rem_d = snd_rem_q - 1'b1;
          if (snd_rem_q == word_t'(1)) begin
            state_d    = WAIT;
            timer_d    = '0;
            frame_sent = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.rails_valid) begin
          out_result_d  = bus.rails_result;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (timer_q == C_TMAX) begin
          out_result_d  = 1'b0;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    frames_ready_d = frames_ready_q + FW'(frame_done) - FW'(frame_sent);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_rem_q       <= '0;
      err_zero_q     <= 1'b0;
      frames_ready_q <= '0;
      state_q        <= IDLE;
      snd_rem_q      <= '0;
      snd_first_q    <= 1'b0;
      timer_q        <= '0;
      rails_data_q   <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= 1'b0;
      out_timeout_q  <= 1'b0;
    end else begin
      wr_rem_q       <= wr_rem_d;
      err_zero_q     <= err_zero_d;
      frames_ready_q <= frames_ready_d;
      state_q        <= state_d;
      snd_rem_q      <= snd_rem_d;
      snd_first_q    <= snd_first_d;
      timer_q        <= timer_d;
      rails_data_q   <= rails_data_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_timeout_q  <= out_timeout_d;
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.rails_data  = rails_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_timeout = out_timeout_q;
  assign err_zero        = err_zero_q;
  assign busy            = (state_q != IDLE) || (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_rails_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rails_feeder : directed bench with a behavioural rails responder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rails_feeder;

  localparam int DEPTH     = 16;
  localparam int TIMEOUT   = 20;
  localparam int RAILS_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  logic err_zero, busy;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;
  bit   mute   = 1'b0;

  bit         ans_q[$];
  logic [3:0] seen_q[$];
  logic [3:0] tail_q[$];
  logic [3:0] exp_w[$];
  int         hdr_t[$];
  int         rv_t[$];
  int         lw_t = 0;
  logic       vr_q[$];
  logic       vt_q[$];
  int         vtime = 0;

  rails_feeder_if bus();

  rails_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err_zero (err_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // rails responder: watches one frame, then answers after RAILS_LAT cycles
  initial begin : rails_model
    int st, left, w;
    st = 0; left = 0; w = 0;
    bus.rails_valid  = 1'b0;
    bus.rails_result = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        st = 0;
        bus.rails_valid = 1'b0;
      end else begin
        case (st)
          0: if (bus.rails_data != 4'd0) begin
               seen_q.push_back(bus.rails_data);
               hdr_t.push_back(cyc);
               left = int'(bus.rails_data);
               st = 1;
             end
          1: begin
               seen_q.push_back(bus.rails_data);
               left--;
               if (left == 0) begin
                 lw_t = cyc;
                 st = 5;
               end
             end
          5: begin
               tail_q.push_back(bus.rails_data);
               w  = RAILS_LAT;
               st = mute ? 0 : 2;
             end
          2: if (w == 0) begin
               bus.rails_valid  = 1'b1;
               bus.rails_result = (ans_q.size() > 0) ? ans_q.pop_front() : 1'b0;
               rv_t.push_back(cyc);
               st = 3;
             end else begin
               w--;
             end
          default: begin
               bus.rails_valid = 1'b0;
               st = 0;
             end
        endcase
      end
    end
  end

  initial begin : verdict_logger
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        vr_q.push_back(bus.out_result);
        vt_q.push_back(bus.out_timeout);
        vtime = cyc;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] wd);
    bit ok;
    int k;
    ok = 1'b0; k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = wd;
    while (!ok && k < 200) begin
      ok = bus.in_ready;
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("push_stall", 0, 1);
  endtask

  task automatic push_frame(input logic [3:0] f[$]);
    foreach (f[i]) push_word(f[i]);
  endtask

  task automatic wait_verdicts(input string tag, input int n);
    int k;
    k = 0;
    while (vr_q.size() < n && k < 500) begin
      tick();
      k++;
    end
    check(tag, 32'(vr_q.size() >= n), 1);
  endtask

  task automatic check_words(input string tag);
    check({tag, "_len"}, seen_q.size(), exp_w.size());
    foreach (exp_w[i]) if (i < seen_q.size()) check(tag, seen_q[i], exp_w[i]);
    seen_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},    bus.in_ready,    1);
    check({tag, "_rails_data"},  bus.rails_data,  0);
    check({tag, "_out_valid"},   bus.out_valid,   0);
    check({tag, "_out_result"},  bus.out_result,  0);
    check({tag, "_out_timeout"}, bus.out_timeout, 0);
    check({tag, "_err_zero"},    err_zero,        0);
    check({tag, "_busy"},        busy,            0);
  endtask

  task automatic clear_logs();
    vr_q.delete(); vt_q.delete(); tail_q.delete();
    hdr_t.delete(); rv_t.delete(); seen_q.delete();
  endtask

  initial begin : stimulus
    bit stable;
    int k;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // single frame, verdict 1
    ans_q.push_back(1'b1);
    exp_w = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    push_frame(exp_w);
    wait_verdicts("t1_wait", 1);
    check("t1_result",  vr_q[0], 1);
    check("t1_timeout", vt_q[0], 0);
    check_words("t1_words");
    check("t1_tail", (tail_q.size() > 0) ? tail_q[0] : 4'hf, 0);
    clear_logs();

    // three queued frames, verdicts 1,0,1
    ans_q.push_back(1'b1); ans_q.push_back(1'b0); ans_q.push_back(1'b1);
    exp_w = '{4'd2, 4'd3, 4'd4};        push_frame(exp_w);
    exp_w = '{4'd3, 4'd7, 4'd8, 4'd9};  push_frame(exp_w);
    exp_w = '{4'd1, 4'd6};              push_frame(exp_w);
    wait_verdicts("t2_wait", 3);
    check("t2_v0", vr_q[0], 1);
    check("t2_v1", vr_q[1], 0);
    check("t2_v2", vr_q[2], 1);
    exp_w = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd7, 4'd8, 4'd9, 4'd1, 4'd6};
    check_words("t2_words");
    check("t2_gap1", hdr_t[1] - rv_t[0], 4);
    check("t2_gap2", hdr_t[2] - rv_t[1], 4);
    clear_logs();

    // fill the 16-deep FIFO with a 15-entry frame
    ans_q.push_back(1'b1); ans_q.push_back(1'b1);
    for (int i = 0; i < 15; i++) push_word((i == 0) ? 4'd15 : 4'(i));
    check("t3_ready_at15", bus.in_ready, 1);
    push_word(4'd15);
    check("t3_full", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd1;
    tick();
    check("t3_still_full", bus.in_ready, 0);
    tick();
    check("t3_rise", bus.in_ready, 1);
    push_word(4'd1);
    push_word(4'd9);
    wait_verdicts("t3_wait", 2);
    exp_w = '{4'd15, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
              4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd1, 4'd9};
    check_words("t3_words");
    clear_logs();

    // rails never answers: timeout verdict, then normal operation resumes
    mute  = 1'b1;
    exp_w = '{4'd1, 4'd5};
    push_frame(exp_w);
    wait_verdicts("t4_wait", 1);
    check("t4_result",  vr_q[0], 0);
    check("t4_timeout", vt_q[0], 1);
    check("t4_latency", vtime - lw_t, TIMEOUT + 1);
    mute = 1'b0;
    ans_q.push_back(1'b1);
    exp_w = '{4'd2, 4'd1, 4'd2};
    push_frame(exp_w);
    wait_verdicts("t4_wait2", 2);
    check("t4_result2",  vr_q[1], 1);
    check("t4_timeout2", vt_q[1], 0);
    exp_w = '{4'd1, 4'd5, 4'd2, 4'd1, 4'd2};
    check_words("t4_words");
    clear_logs();

    // zero header dropped
    push_word(4'd0);
    check("t5_err_zero", err_zero, 1);
    check("t5_not_buffered", busy, 0);
    ans_q.push_back(1'b1);
    exp_w = '{4'd1, 4'd1};
    push_frame(exp_w);
    wait_verdicts("t5_wait", 1);
    check("t5_result", vr_q[0], 1);
    check_words("t5_words");
    check("t5_err_sticky", err_zero, 1);
    clear_logs();

    // host stalls the verdict port with a second frame queued
    bus.out_ready = 1'b0;
    ans_q.push_back(1'b0); ans_q.push_back(1'b1);
    exp_w = '{4'd2, 4'd1, 4'd2}; push_frame(exp_w);
    exp_w = '{4'd1, 4'd3};       push_frame(exp_w);
    k = 0;
    while (!bus.out_valid && k < 200) begin
      tick();
      k++;
    end
    check("t6_valid", bus.out_valid, 1);
    check("t6_result", bus.out_result, 0);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_result !== 1'b0 || bus.out_timeout !== 1'b0)
        stable = 1'b0;
    end
    check("t6_hold", stable, 1);
    check("t6_second_held", hdr_t.size(), 1);
    bus.out_ready = 1'b1;
    wait_verdicts("t6_wait", 2);
    check("t6_v0", vr_q[0], 0);
    check("t6_v1", vr_q[1], 1);
    exp_w = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd3};
    check_words("t6_words");
    clear_logs();

    // reset in the middle of SEND
    exp_w = '{4'd3, 4'd1, 4'd2, 4'd3};
    push_frame(exp_w);
    k = 0;
    while (hdr_t.size() == 0 && k < 100) begin
      tick();
      k++;
    end
    check("t7_in_send", hdr_t.size(), 1);
    reset = 1'b1;
    tick();
    check_reset_state("t7_reset");
    reset = 1'b0;
    ans_q.delete();
    tick();
    clear_logs();
    ans_q.push_back(1'b1);
    exp_w = '{4'd1, 4'd7};
    push_frame(exp_w);
    wait_verdicts("t7_wait", 1);
    check("t7_result", vr_q[0], 1);
    check_words("t7_words");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rails_feeder.md
Name: rails_feeder

Overview:
- Upstream front-end for the rails stack-permutation checker.
- Accepts train-order frames from a host over a valid/ready stream and buffers them in a FIFO.
- Serializes each complete frame into the rails cycle-per-word protocol: one count word, then count order words.
- Captures the rails verdict and returns it to the host through a valid/ready result port, with a timeout guard.

Parameters:
DEPTH, 32, FIFO depth in 4-bit words; power of two, minimum 16.
TIMEOUT, 1023, maximum cycles to wait for rails_valid after the last word is driven.

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  host word valid
in_ready  output  1  feeder can accept a word (= !fifo_full)
in_data  input  4  frame word: first word is num (1..15), then num order words
rails_data  output  4  registered word stream to rails.data
rails_valid  input  1  rails.valid
rails_result  input  1  rails.result
out_valid  output  1  verdict available
out_ready  input  1  host accepts verdict
out_result  output  1  1 = order achievable; forced 0 on timeout
out_timeout  output  1  verdict came from timeout, not from rails
err_zero  output  1  sticky: a num=0 header was received and dropped
busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset values: in_ready=1, rails_data=0, out_valid=0, out_result=0, out_timeout=0, err_zero=0, busy=0. FIFO is emptied and frame counters are cleared.
- Reset mid-operation discards every buffered or partially sent frame. Rails is reset in parallel by the system.
- Write side:
  - A word is accepted when in_valid && in_ready.
  - A write tracker holds wr_rem: 0 means the next word is a header.
  - Header with num=0: not written, sets err_zero.
  - Header with num>0: written, wr_rem=num.
  - Order word: written, wr_rem decrements.
  - When a write brings wr_rem to 0, frames_ready increments.
  - Order-word values are passed through unchecked.
- FIFO:
  - Show-ahead head, count in 0..DEPTH.
  - Full when count==DEPTH. Push while full is impossible because in_ready=0.
  - Simultaneous push and pop is legal in any state, including full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Send FSM, states IDLE, SEND, WAIT, RESP:
  - IDLE: if frames_ready>0 && !out_valid, go to SEND.
  - SEND: each cycle pop the head into rails_data; the first pop loads snd_rem=head.
    - A frame of num entries occupies num+1 consecutive cycles of rails_data. Words are contiguous and never stall, because the frame is fully buffered.
    - After the last word: rails_data=0, frames_ready decrements, timer=0, go to WAIT.
    - A frames_ready increment and decrement in the same cycle cancel.
  - WAIT:
    - On rails_valid: out_result=rails_result, out_timeout=0, out_valid=1, go to RESP.
    - Else if timer==TIMEOUT: out_result=0, out_timeout=1, out_valid=1, go to RESP.
    - Else timer+1.
  - RESP: hold outputs while out_valid && !out_ready. On handshake, out_valid=0 and go to IDLE.
- rails_valid outside WAIT is ignored.
- Minimum gap from rails_valid to the next header on rails_data is 2 cycles (RESP plus IDLE).
- Verdicts are delivered in frame order, one per frame.
- Latency: IDLE→SEND at edge T; header visible on rails_data after edge T+1; last order word after edge T+1+num.

Decomposition:
- Shared package rails_pkg:
  - DATA_W=4
  - MAX_N=15
  - typedef of the 4-bit word
  - enum for the FSM states {IDLE,SEND,WAIT,RESP}
- Sub-module rails_feed_fifo: parameterized DEPTH show-ahead synchronous FIFO with full/empty/count. Shared with future rails-side buffers.
- Write tracker and send FSM stay in rails_feeder.

Test Plan:
- Frame 5,1,2,3,4,5 followed by a behavioural rails model returning result=1 → rails_data shows 5,1,2,3,4,5 on 6 consecutive cycles, then 0. out_valid=1, out_result=1, out_timeout=0.
- Three frames pushed back-to-back while the first is in WAIT (rails model answers 1,0,1) → three contiguous bursts, each preceded by a gap of at least 2 cycles; verdicts 1,0,1 in order.
- DEPTH=16, push a 15-word frame plus header, then further words → in_ready=0 exactly when count=16. It rises the cycle after the first SEND pop; no word is lost or duplicated.
- Rails model never asserts valid → after the last word plus TIMEOUT+1 cycles: out_valid=1, out_result=0, out_timeout=1. The next frame then proceeds normally.
- Header 0 followed by frame 1,1 → err_zero=1 and stays 1; only 1,1 appears on rails_data.
- out_ready held low for 20 cycles with two frames queued → out_result is held stable and the second frame is not sent until the handshake. Assert reset mid-SEND → all outputs return to reset values the next cycle and the FIFO is empty.
